// File: rtl/rf_wb_ctrl_if.sv
// rtl/rf_wb_ctrl_if.sv - issue, data-memory and register-file bundle for rf_wb_ctrl
interface rf_wb_ctrl_if;
   logic       IssueValid;
   logic       IssueReady;
   logic [1:0] IssueSrc;
   logic       IssueRegWr;
   logic [4:0] IssueRd;
   logic       MemReqValid;
   logic       MemReqReady;
   logic       MemRspValid;
   logic [1:0] RUDataWrSrc;
   logic       RUWr;
   logic [4:0] RdWr;
   logic       LoadPending;
   logic [4:0] PendingRd;
   logic       LoadErr;
   logic       IllegalSrc;

   modport master (
      output IssueValid, IssueSrc, IssueRegWr, IssueRd, MemReqReady, MemRspValid,
      input  IssueReady, MemReqValid, RUDataWrSrc, RUWr, RdWr, LoadPending,
             PendingRd, LoadErr, IllegalSrc
   );

   modport slave (
      input  IssueValid, IssueSrc, IssueRegWr, IssueRd, MemReqReady, MemRspValid,
      output IssueReady, MemReqValid, RUDataWrSrc, RUWr, RdWr, LoadPending,
             PendingRd, LoadErr, IllegalSrc
   );
endinterface

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - RV32I writeback sequencer with load handshake and timeout
module rf_wb_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   rf_wb_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT, LD_WB} state_t;

   localparam logic [1:0]       SRC_ALU  = 2'b00;
   localparam logic [1:0]       SRC_LOAD = 2'b01;
   localparam logic [1:0]       SRC_ILL  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ld_wr_q, ld_wr_d;
   logic [4:0]       ld_rd_q, ld_rd_d;
   logic             ru_wr_q, ru_wr_d;
   logic [4:0]       rd_wr_q, rd_wr_d;
   logic [1:0]       src_q, src_d;
   logic             pend_q, pend_d;
   logic [4:0]       pend_rd_q, pend_rd_d;
   logic             err_q, err_d;
   logic             ill_q, ill_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ld_wr_d   = ld_wr_q;
      ld_rd_d   = ld_rd_q;
      ru_wr_d   = 1'b0;
      rd_wr_d   = rd_wr_q;
      src_d     = src_q;
      pend_d    = pend_q;
      pend_rd_d = pend_rd_q;
      err_d     = 1'b0;
      ill_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.IssueValid) begin
               if (bus.IssueSrc == SRC_LOAD) begin
                  state_d   = LD_REQ;
                  ld_rd_d   = bus.IssueRd;
                  ld_wr_d   = bus.IssueRegWr;
                  pend_d    = 1'b1;
                  pend_rd_d = bus.IssueRegWr ? bus.IssueRd : 5'd0;
               end else begin
                  // Illegal source still retires, but never writes and reports ALU on the mux.
                  ill_d   = (bus.IssueSrc == SRC_ILL);
                  ru_wr_d = !ill_d && bus.IssueRegWr && (bus.IssueRd != 5'd0);
                  rd_wr_d = bus.IssueRd;
                  src_d   = ill_d ? SRC_ALU : bus.IssueSrc;
               end
            end
         end
         LD_REQ: begin
            if (bus.MemReqReady) begin
               state_d = LD_WAIT;
               cnt_d   = '0;
            end
         end
         LD_WAIT: begin
            // A response on the expiry cycle takes priority over the timeout.
            if (bus.MemRspValid) begin
               state_d   = LD_WB;
               ru_wr_d   = ld_wr_q && (ld_rd_q != 5'd0);
               rd_wr_d   = ld_rd_q;
               src_d     = SRC_LOAD;
               pend_d    = 1'b0;
               pend_rd_d = 5'd0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               err_d     = 1'b1;
               pend_d    = 1'b0;
               pend_rd_d = 5'd0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LD_WB: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ld_wr_q   <= 1'b0;
         ld_rd_q   <= 5'd0;
         ru_wr_q   <= 1'b0;
         rd_wr_q   <= 5'd0;
         src_q     <= 2'b00;
         pend_q    <= 1'b0;
         pend_rd_q <= 5'd0;
         err_q     <= 1'b0;
         ill_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ld_wr_q   <= ld_wr_d;
         ld_rd_q   <= ld_rd_d;
         ru_wr_q   <= ru_wr_d;
         rd_wr_q   <= rd_wr_d;
         src_q     <= src_d;
         pend_q    <= pend_d;
         pend_rd_q <= pend_rd_d;
         err_q     <= err_d;
         ill_q     <= ill_d;
      end
   end

   assign bus.IssueReady  = (state_q == IDLE);
   assign bus.MemReqValid = (state_q == LD_REQ);
   assign bus.RUWr        = ru_wr_q;
   assign bus.RdWr        = rd_wr_q;
   assign bus.RUDataWrSrc = src_q;
   assign bus.LoadPending = pend_q;
   assign bus.PendingRd   = pend_rd_q;
   assign bus.LoadErr     = err_q;
   assign bus.IllegalSrc  = ill_q;
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb/tb_rf_wb_ctrl.sv - self-checking bench for rf_wb_ctrl
module tb_rf_wb_ctrl;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   rf_wb_ctrl_if bus ();

   rf_wb_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Transaction-level model: one in-flight load record, write/pulse expectations per cycle.
   bit         m_busy, m_granted, m_wb, m_regwr;
   int         m_waited;
   logic [4:0] m_rd;
   bit         e_wr, e_err, e_ill, e_pend;
   logic [4:0] e_prd, e_rdwr;
   logic [1:0] e_src;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_granted = 0; m_wb = 0; m_regwr = 0; m_waited = 0; m_rd = 0;
         e_wr = 0; e_err = 0; e_ill = 0; e_pend = 0; e_prd = 0; e_rdwr = 0; e_src = 0;
      end else begin
         e_wr = 0; e_err = 0; e_ill = 0;
         if (!m_busy) begin
            if (bus.IssueValid) begin
               if (bus.IssueSrc == 2'd1) begin
                  m_busy = 1; m_granted = 0; m_wb = 0;
                  m_rd = bus.IssueRd; m_regwr = bus.IssueRegWr;
                  e_pend = 1; e_prd = bus.IssueRegWr ? bus.IssueRd : 5'd0;
               end else begin
                  e_ill  = (bus.IssueSrc == 2'd3);
                  e_wr   = !e_ill && bus.IssueRegWr && bus.IssueRd != 0;
                  e_rdwr = bus.IssueRd;
                  e_src  = e_ill ? 2'd0 : bus.IssueSrc;
               end
            end
         end else if (m_wb) begin
            m_busy = 0;
         end else if (!m_granted) begin
            if (bus.MemReqReady) begin m_granted = 1; m_waited = 0; end
         end else if (bus.MemRspValid) begin
            m_wb = 1; e_wr = m_regwr && m_rd != 0; e_rdwr = m_rd; e_src = 2'd1;
            e_pend = 0; e_prd = 0;
         end else begin
            m_waited++;
            if (m_waited == TMO) begin
               m_busy = 0; e_err = 1; e_pend = 0; e_prd = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("IssueReady", bus.IssueReady, !m_busy);
      chk("MemReqValid", bus.MemReqValid, m_busy && !m_granted);
      chk("RUWr", bus.RUWr, e_wr);
      chk("LoadPending", bus.LoadPending, e_pend);
      chk("PendingRd", bus.PendingRd, e_prd);
      chk("LoadErr", bus.LoadErr, e_err);
      chk("IllegalSrc", bus.IllegalSrc, e_ill);
      if (e_wr) chk("RdWr", bus.RdWr, e_rdwr);
      if (e_wr || e_ill) chk("RUDataWrSrc", bus.RUDataWrSrc, e_src);
   end

   task automatic issue(input logic [1:0] s, input logic w, input logic [4:0] r);
      bus.IssueValid = 1'b1;
      bus.IssueSrc   = s;
      bus.IssueRegWr = w;
      bus.IssueRd    = r;
      @(negedge clk);
      bus.IssueValid = 1'b0;
   endtask

   initial begin
      bus.IssueValid = 0; bus.IssueSrc = 0; bus.IssueRegWr = 0; bus.IssueRd = 0;
      bus.MemReqReady = 0; bus.MemRspValid = 0;
      #1;
      chk("rst_ready", bus.IssueReady, 1);
      chk("rst_ruwr", bus.RUWr, 0);
      chk("rst_rdwr", bus.RdWr, 0);
      chk("rst_pend", bus.LoadPending, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // back-to-back ALU rd5, PC+4 rd1
      issue(2'd0, 1'b1, 5'd5);
      chk("b2b_wr0", bus.RUWr, 1); chk("b2b_rd0", bus.RdWr, 5); chk("b2b_src0", bus.RUDataWrSrc, 0);
      issue(2'd2, 1'b1, 5'd1);
      chk("b2b_wr1", bus.RUWr, 1); chk("b2b_rd1", bus.RdWr, 1); chk("b2b_src1", bus.RUDataWrSrc, 2);
      @(negedge clk);
      chk("b2b_idle", bus.RUWr, 0);

      // load rd7, grant after 3 low cycles, response 4 cycles after grant
      bus.MemReqReady = 0;
      issue(2'd1, 1'b1, 5'd7);
      chk("ld_prd", bus.PendingRd, 7); chk("ld_req", bus.MemReqValid, 1);
      repeat (3) @(negedge clk);
      bus.MemReqReady = 1;
      @(negedge clk);
      bus.MemReqReady = 0;
      repeat (3) @(negedge clk);
      chk("ld_wait_rdy", bus.IssueReady, 0);
      bus.MemRspValid = 1;
      @(negedge clk);
      bus.MemRspValid = 0;
      chk("ld_wr", bus.RUWr, 1); chk("ld_rd", bus.RdWr, 7); chk("ld_src", bus.RUDataWrSrc, 1);
      chk("ld_rdy_wb", bus.IssueReady, 0);
      @(negedge clk);
      chk("ld_rdy_after", bus.IssueReady, 1);

      // timeout, then new ALU op accepted
      bus.MemReqReady = 1;
      issue(2'd1, 1'b1, 5'd9);
      repeat (5) @(negedge clk);
      chk("tmo_err", bus.LoadErr, 1); chk("tmo_nowr", bus.RUWr, 0); chk("tmo_rdy", bus.IssueReady, 1);
      issue(2'd0, 1'b1, 5'd4);
      chk("tmo_alu_wr", bus.RUWr, 1); chk("tmo_alu_rd", bus.RdWr, 4);

      // response on the expiry cycle wins
      issue(2'd1, 1'b1, 5'd10);
      repeat (4) @(negedge clk);
      bus.MemRspValid = 1;
      @(negedge clk);
      bus.MemRspValid = 0;
      chk("exp_wr", bus.RUWr, 1); chk("exp_rd", bus.RdWr, 10); chk("exp_err", bus.LoadErr, 0);
      @(negedge clk);

      // rd=x0 for ALU and load, then illegal source
      issue(2'd0, 1'b1, 5'd0);
      chk("x0_alu", bus.RUWr, 0);
      issue(2'd1, 1'b1, 5'd0);
      chk("x0_ld_req", bus.MemReqValid, 1); chk("x0_ld_prd", bus.PendingRd, 0);
      @(negedge clk);
      bus.MemRspValid = 1;
      @(negedge clk);
      bus.MemRspValid = 0;
      chk("x0_ld_wr", bus.RUWr, 0); chk("x0_ld_pend", bus.LoadPending, 0);
      @(negedge clk);
      issue(2'd3, 1'b1, 5'd3);
      chk("ill_pulse", bus.IllegalSrc, 1); chk("ill_wr", bus.RUWr, 0); chk("ill_src", bus.RUDataWrSrc, 0);
      @(negedge clk);
      chk("ill_once", bus.IllegalSrc, 0);

      // stray response while idle
      bus.MemRspValid = 1;
      repeat (2) @(negedge clk);
      bus.MemRspValid = 0;

      // asynchronous reset during LD_WAIT
      issue(2'd1, 1'b1, 5'd11);
      @(negedge clk);
      chk("rst_ld_pend_pre", bus.LoadPending, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", bus.MemReqValid, 0); chk("arst_pend", bus.LoadPending, 0);
      chk("arst_wr", bus.RUWr, 0); chk("arst_rdy", bus.IssueReady, 1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      bus.MemRspValid = 1;
      @(negedge clk);
      chk("late_rsp_wr", bus.RUWr, 0); chk("late_rsp_rdy", bus.IssueReady, 1);
      repeat (2) @(negedge clk);
      bus.MemRspValid = 0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
- Writeback controller for the RV32I core's single register-file write port.
- Accepts retiring instructions and sequences the writeback-source select (ALU, data memory, PC+4) and the register write enable.
- Runs the load handshake with data memory: request, wait, response, timeout.
- Stalls issue while a load is outstanding and exposes the pending destination register for hazard logic.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in LD_WAIT before the load is aborted.
- CNT_W, 8: width of the timeout counter. Requirement: 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IssueValid  in  1  an instruction is presented for writeback.
- IssueReady  out  1  controller accepts the instruction this cycle.
- IssueSrc  in  2  source: 00 ALU, 01 load, 10 PC+4, 11 illegal.
- IssueRegWr  in  1  instruction writes rd.
- IssueRd  in  5  destination register.
- MemReqValid  out  1  load request to data memory.
- MemReqReady  in  1  memory accepts the request.
- MemRspValid  in  1  load data valid on DataRd this cycle.
- RUDataWrSrc  out  2  writeback mux select; encoding identical to IssueSrc.
- RUWr  out  1  register-file write enable.
- RdWr  out  5  register-file write address.
- LoadPending  out  1  a load is in flight.
- PendingRd  out  5  rd of the in-flight load; 0 when none.
- LoadErr  out  1  one-cycle pulse on load timeout.
- IllegalSrc  out  1  one-cycle pulse when IssueSrc=11 is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0. Exception: IssueReady=1 in IDLE, since it is combinational from state.
- Reset mid-load forces IDLE immediately: MemReqValid=0, no write, the load is dropped.
- States:
  - IDLE: IssueReady=1.
  - LD_REQ: MemReqValid=1, IssueReady=0.
  - LD_WAIT: IssueReady=0, counter running.
  - LD_WB: one cycle, IssueReady=0.
- Acceptance: a transfer happens when IssueValid & IssueReady at a rising edge.
- ALU or PC+4 accepted in cycle N:
  - In cycle N+1: RUWr=IssueRegWr & (IssueRd!=0), RdWr=IssueRd, RUDataWrSrc=IssueSrc.
  - State stays IDLE, so back-to-back issue gives one write per cycle.
- Load accepted: go to LD_REQ. Latch rd and regwr.
  - LoadPending=1 from the next cycle.
  - PendingRd=latched rd, or 0 if IssueRegWr=0.
- LD_REQ: hold MemReqValid until MemReqReady. Then go to LD_WAIT and clear the counter.
- LD_WAIT: counter increments each cycle without MemRspValid.
  - MemRspValid: go to LD_WB. Then in the next cycle: RUWr=latched regwr & rd!=0, RdWr=latched rd, RUDataWrSrc=01.
  - Counter reaches TIMEOUT_CYCLES without a response: LoadErr pulses 1 cycle, return to IDLE, no write.
  - MemRspValid in the same cycle as counter expiry: the response wins and LoadErr stays 0.
- LD_WB → IDLE.
  - LoadPending and PendingRd clear in the cycle RUWr is asserted for the load.
  - IssueReady returns to 1 in the following cycle.
- Load-to-write latency = 2 + (cycles MemReqReady low) + (response wait) cycles.
- rd=x0: the instruction is fully sequenced, including the memory handshake for a load. RUWr stays 0.
- IssueSrc=11: accepted, no write, IllegalSrc pulses in N+1, RUDataWrSrc=00.
- MemRspValid outside LD_WAIT: ignored.
- Between writes: RUWr=0. RdWr and RUDataWrSrc hold their last values.

Test Plan:
- Reset, then ALU op rd=5 at cycle 1, PC+4 op rd=1 at cycle 2 → RUWr=1 in cycles 2 and 3, RdWr=5 then 1, RUDataWrSrc=00 then 10.
- Load rd=7, MemReqReady low 3 cycles, response 4 cycles after grant → IssueReady=0 throughout, LoadPending=1 with PendingRd=7, RUWr=1 with RdWr=7 and src=01 exactly one cycle after MemRspValid, IssueReady=1 the next cycle.
- Load with no response, TIMEOUT_CYCLES=4 → LoadErr pulses once after 4 LD_WAIT cycles, no RUWr, controller accepts a new ALU op afterwards. Repeat with MemRspValid on the expiry cycle → write occurs and LoadErr stays 0.
- ALU op rd=0, load rd=0, IssueSrc=11 rd=3 → RUWr never 1, the load still completes its handshake, IllegalSrc pulses once.
- Assert rst_n=0 during LD_WAIT → MemReqValid, LoadPending and RUWr drop asynchronously. After release: IssueReady=1, and a late MemRspValid causes no write.
